// File: rtl/adder_tree_pipe.sv
// adder_tree_pipe: fully pipelined 2**LEVELS-lane adder tree with valid/ready flow control,
// per-stage bubble collapse and optional accumulation of tree sums across beats up to in_last.
module adder_tree_pipe #(
    parameter int  WIDTH      = 12,
    parameter int  LEVELS     = 3,
    parameter int  SIGNED     = 0,
    parameter int  ACCUMULATE = 0,
    parameter int  ACC_BITS   = 4,
    localparam int N          = 1 << LEVELS,
    localparam int OW         = WIDTH + LEVELS + ((ACCUMULATE != 0) ? ACC_BITS : 0)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_data
);
    localparam int SW = WIDTH + LEVELS;

    logic [LEVELS:0] v_q;
    logic [LEVELS:0] l_q;
    logic [LEVELS:0] v_in;
    logic [LEVELS:0] l_in;
    logic [LEVELS:0] rdy;
    logic            rdy_out;
    logic [SW-1:0]   sum_w;

    assign v_in = {v_q[LEVELS-1:0], in_valid};
    assign l_in = {l_q[LEVELS-1:0], (ACCUMULATE != 0) & in_last};

    // A stage can load when it or any stage downstream of it has a hole; written flat
    // rather than as a recursive chain so each bit depends only on registers.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_rdy
        assign rdy[k] = rdy_out | ~(&v_q[LEVELS:k]);
    end
    assign in_ready = rdy[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            l_q <= '0;
        end else begin
            for (int k = 0; k <= LEVELS; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_in[k];
                    l_q[k] <= l_in[k];
                end
            end
        end
    end

    for (genvar k = 0; k <= LEVELS; k++) begin : g_stg
        localparam int NW = WIDTH + k;
        localparam int NN = N >> k;

        logic [NN*NW-1:0] data_q;
        logic [NN*NW-1:0] data_d;

        if (k == 0) begin : g_in
            assign data_d = in_data;
        end else begin : g_sum
            logic [2*NN*(NW-1)-1:0] prev;
            assign prev = g_stg[k-1].data_q;

            // Each operand is widened by one bit (sign or zero) so the pair sum cannot overflow.
            always_comb begin
                data_d = '0;
                for (int j = 0; j < NN; j++) begin
                    data_d[j*NW +: NW] =
                        {(SIGNED != 0) & prev[(2*j+1)*(NW-1)-1], prev[2*j*(NW-1) +: NW-1]} +
                        {(SIGNED != 0) & prev[(2*j+2)*(NW-1)-1], prev[(2*j+1)*(NW-1) +: NW-1]};
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (rdy[k] && v_in[k]) begin
                data_q <= data_d;
            end
        end
    end

    assign sum_w = g_stg[LEVELS].data_q;

    if (ACCUMULATE != 0) begin : g_acc
        logic [OW-1:0] acc_q, acc_d, sum_ext;
        logic          open_q, open_d;
        logic          ov_q, ov_d;
        logic          consume;

        // The tree output is held back while a finished result is still waiting.
        assign rdy_out = !ov_q | out_ready;
        assign consume = v_q[LEVELS] & rdy_out;
        assign sum_ext = {{(OW-SW){(SIGNED != 0) & sum_w[SW-1]}}, sum_w};

        always_comb begin
            acc_d  = acc_q;
            open_d = open_q;
            ov_d   = ov_q;
            if (consume) begin
                acc_d  = (open_q ? acc_q : '0) + sum_ext;
                open_d = !l_q[LEVELS];
                ov_d   = l_q[LEVELS];
            end else if (ov_q && out_ready) begin
                ov_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q  <= '0;
                open_q <= 1'b0;
                ov_q   <= 1'b0;
            end else begin
                acc_q  <= acc_d;
                open_q <= open_d;
                ov_q   <= ov_d;
            end
        end

        assign out_valid = ov_q;
        assign out_data  = acc_q;
    end else begin : g_dir
        logic unused_last;

        assign unused_last = l_q[LEVELS];
        assign rdy_out     = out_ready;
        assign out_valid   = v_q[LEVELS];
        assign out_data    = sum_w;
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: three instances (unsigned, signed, accumulate) driven with directed and
// random beats; a queue-based reference model computes the expected sums from the lane values.
module tb_adder_tree_pipe;
    localparam int W = 12;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv [3];
    logic        il [3];
    logic        orr [3];
    logic        ir [3];
    logic        ov [3];
    logic [95:0] id [3];
    logic [14:0] od0, od1;
    logic [18:0] od2;

    int     checks = 0;
    int     failures = 0;
    longint q [3][$];
    longint grp [3];
    bit     hold [3];
    longint hdat [3];
    bit     done;

    always #5 clk = ~clk;

    adder_tree_pipe u_dut0 (.clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .in_last(il[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od0));
    adder_tree_pipe #(.SIGNED(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .in_last(il[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od1));
    adder_tree_pipe #(.ACCUMULATE(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .in_last(il[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od2));

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint lane_sum(input logic [95:0] d, input bit sgn);
        longint s;
        logic [11:0] ln;
        s = 0;
        for (int i = 0; i < N; i++) begin
            ln = d[i*W +: W];
            s += sgn ? longint'($signed(ln)) : longint'(ln);
        end
        return s;
    endfunction

    function automatic longint mask(input int ow);
        return (longint'(1) << ow) - 1;
    endfunction

    function automatic logic [95:0] lane0(input int v);
        logic [95:0] d;
        d = '0;
        d[11:0] = 12'(v);
        return d;
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic mon(input int k);
        longint od;
        longint m;
        od = (k == 0) ? longint'(od0) : (k == 1) ? longint'(od1) : longint'(od2);
        m  = mask((k == 2) ? 19 : 15);
        if (!rst_n) begin
            q[k].delete();
            grp[k]  = 0;
            hold[k] = 0;
            return;
        end
        if (hold[k]) begin
            check_eq("hold_valid", ov[k], 1);
            check_eq("hold_data", od, hdat[k]);
        end
        if (k < 2 && !ir[k]) check_eq("stall_only_when_full", q[k].size(), 4);
        if (iv[k] && ir[k]) begin
            if (k == 2) begin
                grp[k] += lane_sum(id[k], 1'b0);
                if (il[k]) begin
                    q[k].push_back(grp[k] & m);
                    grp[k] = 0;
                end
            end else begin
                q[k].push_back(lane_sum(id[k], k == 1) & m);
            end
        end
        if (ov[k] && orr[k]) begin
            check_eq("out_expected", q[k].size() != 0, 1);
            if (q[k].size() != 0) check_eq("out_data", od, q[k].pop_front());
        end
        hold[k] = ov[k] & !orr[k];
        hdat[k] = od;
    endtask

    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 3; k++) mon(k);
    end

    task automatic push(input logic [2:0] m, input logic [95:0] d, input logic last);
        int t;
        bit ok;
        @(negedge clk);
        for (int k = 0; k < 3; k++) if (m[k]) begin iv[k] = 1'b1; id[k] = d; il[k] = last; end
        t = 0;
        forever begin
            #1;
            ok = 1;
            for (int k = 0; k < 3; k++) if (m[k] && !ir[k]) ok = 0;
            if (ok || t == 60) break;
            @(negedge clk);
            t++;
        end
        if (!ok) check_eq("push_timeout", ok, 1);
    endtask

    task automatic idle(input logic [2:0] m);
        @(negedge clk);
        for (int k = 0; k < 3; k++) if (m[k]) iv[k] = 1'b0;
    endtask

    // One closed beat into all three idle pipes; checks exact latency and the sums.
    task automatic one_beat(input logic [95:0] d, input longint e0, input longint e1, input longint e2);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin iv[k] = 1'b1; id[k] = d; il[k] = 1'b1; end
        #1;
        check_eq("beat_accept", ir[0] & ir[1] & ir[2], 1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) for (int k = 0; k < 3; k++) iv[k] = 1'b0;
            #1;
            check_eq("lat_u0", ov[0], c == 4);
            check_eq("lat_u1", ov[1], c == 4);
            check_eq("lat_u2", ov[2], c == 5);
            if (c == 4) begin
                check_eq("sum_u0", od0, e0);
                check_eq("sum_u1", od1, e1);
            end
            if (c == 5) check_eq("sum_u2", od2, e2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        longint dat;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; il[k] = 1'b0; orr[k] = 1'b1; id[k] = '0;
            grp[k] = 0; hold[k] = 0; hdat[k] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_out_valid", ov[k], 0);
            check_eq("rst_in_ready", ir[k], 1);
        end
        check_eq("rst_od0", od0, 0);
        check_eq("rst_od1", od1, 0);
        check_eq("rst_od2", od2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // lanes 1..8, all-ones, all-MSB
        one_beat({12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1}, 36, 36, 36);
        one_beat({8{12'hFFF}}, 'h7FF8, 'h7FF8, 32760);
        one_beat({8{12'h800}}, 'h4000, 'h4000, 16384);

        // back-to-back stream with out_ready pattern 1-0-0
        done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) push(3'b011, rnd96(), 1'b0);
                idle(3'b011);
                done = 1;
            end
            begin
                int tc;
                tc = 0;
                while (!done) begin
                    @(negedge clk);
                    orr[0] = (tc % 3 == 0);
                    orr[1] = orr[0];
                    tc++;
                end
            end
        join
        orr[0] = 1'b1; orr[1] = 1'b1;
        repeat (8) @(negedge clk);

        // random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) push(3'b011, rnd96(), 1'b0);
                idle(3'b011);
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    orr[0] = 1'($urandom_range(0, 1));
                    orr[1] = orr[0];
                end
            end
        join
        orr[0] = 1'b1; orr[1] = 1'b1;
        repeat (8) @(negedge clk);

        // fill with sink stalled: exactly LEVELS+1 beats accepted
        cnt = 0;
        orr[0] = 1'b0; orr[1] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            iv[0] = 1'b1; iv[1] = 1'b1; id[0] = rnd96(); id[1] = id[0];
            #1;
            if (ir[0]) cnt++;
        end
        check_eq("fill_count", cnt, 4);
        idle(3'b011);
        orr[0] = 1'b1; orr[1] = 1'b1;
        repeat (8) @(negedge clk);

        // accumulation 10+20+30, then 5
        push(3'b100, lane0(10), 1'b0);
        push(3'b100, lane0(20), 1'b0);
        push(3'b100, lane0(30), 1'b1);
        idle(3'b100);
        cnt = 0; dat = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (ov[2]) begin cnt++; dat = od2; end
        end
        check_eq("acc_pulses", cnt, 1);
        check_eq("acc_60", dat, 60);
        push(3'b100, lane0(5), 1'b1);
        idle(3'b100);
        cnt = 0; dat = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (ov[2]) begin cnt++; dat = od2; end
        end
        check_eq("acc2_pulses", cnt, 1);
        check_eq("acc_5", dat, 5);

        // result held while next group queues behind it
        orr[2] = 1'b0;
        push(3'b100, lane0(100), 1'b1);
        push(3'b100, lane0(3), 1'b0);
        push(3'b100, lane0(4), 1'b1);
        idle(3'b100);
        repeat (8) @(negedge clk);
        #1;
        check_eq("held_valid", ov[2], 1);
        check_eq("held_data", od2, 100);
        @(negedge clk);
        orr[2] = 1'b1;
        #1;
        check_eq("release_data", od2, 100);
        cnt = 0;
        do begin
            @(negedge clk); #1;
            cnt++;
        end while (!ov[2] && cnt < 10);
        check_eq("next_group_valid", ov[2], 1);
        check_eq("next_group_sum", od2, 7);
        repeat (3) @(negedge clk);

        // random accumulation with backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 30; i++) push(3'b100, rnd96(), 1'($urandom_range(0, 2) == 0));
                push(3'b100, rnd96(), 1'b1);
                idle(3'b100);
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    orr[2] = 1'($urandom_range(0, 1));
                end
            end
        join
        orr[2] = 1'b1;
        repeat (10) @(negedge clk);

        // reset with beats in flight and an open group
        fork
            begin
                for (int i = 0; i < 3; i++) push(3'b011, rnd96(), 1'b0);
            end
            begin
                for (int i = 0; i < 2; i++) push(3'b100, lane0(9), 1'b0);
            end
        join
        idle(3'b111);
        @(posedge clk);
        #2;
        check_eq("pre_rst_valid", ov[0], 1);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_eq("async_rst_valid", ov[k], 0);
        check_eq("async_rst_od0", od0, 0);
        check_eq("async_rst_od2", od2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        one_beat(lane0(5), 5, 5, 5);

        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) check_eq("drained", q[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
